// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencer.
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    SeqIdle    = 3'd0,
    SeqFetch   = 3'd1,
    SeqDecode  = 3'd2,
    SeqExecute = 3'd3,
    SeqMem     = 3'd4,
    SeqWb      = 3'd5,
    SeqTrap    = 3'd6
  } seq_state_e;

  typedef enum logic [1:0] {
    CauseNone    = 2'd0,
    CauseIllegal = 2'd1,
    CauseImemTo  = 2'd2,
    CauseDmemTo  = 2'd3
  } trap_cause_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  function automatic logic opc_legal(input logic [6:0] opc);
    logic legal;
    unique case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL,
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: legal = 1'b1;
      default:                                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Control/handshake bundle between the sequencer and the rest of the core.
interface core_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic             halt_req;
  logic [6:0]       opcode;
  logic             imem_ready;
  logic             dmem_ready;
  logic             fetch_en;
  logic             DecoderEnable;
  logic             exec_en;
  logic             mem_rd;
  logic             mem_wr;
  logic             reg_we;
  logic             pc_we;
  logic             busy;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, halt_req, opcode, imem_ready, dmem_ready,
    output fetch_en, DecoderEnable, exec_en, mem_rd, mem_wr, reg_we, pc_we,
           busy, trap, trap_cause, instr_count
  );

  modport slave (
    output start, halt_req, opcode, imem_ready, dmem_ready,
    input  fetch_en, DecoderEnable, exec_en, mem_rd, mem_wr, reg_we, pc_we,
           busy, trap, trap_cause, instr_count
  );
endinterface

// File: rtl/core_sequencer_wait_timer.sv
// Bounded wait counter shared by the fetch and memory handshakes.
module core_sequencer_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);
  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] value_q;

  // expired flags the LIMIT-th consecutive non-ready cycle while it is happening
  assign expired = (value_q == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else if (clear) begin
      value_q <= '0;
    end else if (count && !expired) begin
      value_q <= value_q + W'(1);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback with sticky trap.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  core_sequencer_if.master bus
);

  seq_state_e       state_q;
  logic [6:0]       op_q;
  logic             trap_q;
  trap_cause_e      cause_q;
  logic [CNT_W-1:0] count_q;

  logic is_load, is_store, is_branch;
  logic waiting, expired, retire;

  assign is_load   = (op_q == OPC_LOAD);
  assign is_store  = (op_q == OPC_STORE);
  assign is_branch = (op_q == OPC_BRANCH);

  assign waiting = ((state_q == SeqFetch) && !bus.imem_ready) ||
                   ((state_q == SeqMem) && !bus.dmem_ready);

  assign retire = ((state_q == SeqExecute) && is_branch) ||
                  ((state_q == SeqMem) && is_store && bus.dmem_ready) ||
                  (state_q == SeqWb);

  // Any non-waiting cycle clears the timer, so every FETCH/MEM entry starts from zero.
  core_sequencer_wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting),
    .count   (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SeqIdle;
      op_q    <= '0;
      trap_q  <= 1'b0;
      cause_q <= CauseNone;
      count_q <= '0;
    end else begin
      unique case (state_q)
        SeqIdle: begin
          if (bus.start) state_q <= SeqFetch;
        end
        SeqFetch: begin
          if (bus.imem_ready) begin
            state_q <= SeqDecode;
          end else if (expired) begin
            state_q <= SeqTrap;
            trap_q  <= 1'b1;
            cause_q <= CauseImemTo;
          end
        end
        SeqDecode: begin
          op_q <= bus.opcode;
          if (opc_legal(bus.opcode)) begin
            state_q <= SeqExecute;
          end else begin
            state_q <= SeqTrap;
            trap_q  <= 1'b1;
            cause_q <= CauseIllegal;
          end
        end
        SeqExecute: begin
          if (is_load || is_store) state_q <= SeqMem;
          else if (!is_branch)     state_q <= SeqWb;
        end
        SeqMem: begin
          if (bus.dmem_ready) begin
            if (is_load) state_q <= SeqWb;
          end else if (expired) begin
            state_q <= SeqTrap;
            trap_q  <= 1'b1;
            cause_q <= CauseDmemTo;
          end
        end
        SeqWb:   ;
        SeqTrap: ;
        default: state_q <= SeqIdle;
      endcase

      // Retire overrides the per-state next state chosen above.
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
        state_q <= bus.halt_req ? SeqIdle : SeqFetch;
      end
    end
  end

  always_comb begin
    bus.fetch_en      = 1'b0;
    bus.DecoderEnable = 1'b0;
    bus.exec_en       = 1'b0;
    bus.mem_rd        = 1'b0;
    bus.mem_wr        = 1'b0;
    bus.reg_we        = 1'b0;
    unique case (state_q)
      SeqFetch:   bus.fetch_en      = 1'b1;
      SeqDecode:  bus.DecoderEnable = 1'b1;
      SeqExecute: bus.exec_en       = 1'b1;
      SeqMem: begin
        bus.mem_rd = is_load;
        bus.mem_wr = is_store;
      end
      SeqWb:      bus.reg_we        = 1'b1;
      default:    ;
    endcase
  end

  assign bus.pc_we       = retire;
  assign bus.busy        = (state_q != SeqIdle) && (state_q != SeqTrap);
  assign bus.trap        = trap_q;
  assign bus.trap_cause  = cause_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-cycle strobe vectors plus trap/counter checks.
module tb_core_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  core_sequencer_if #(.CNT_W(32)) bus ();

  core_sequencer #(
    .CNT_W   (32),
    .TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fetch_en, DecoderEnable, exec_en, mem_rd, mem_wr, reg_we, pc_we, busy}
  logic [7:0] strb;
  assign strb = {bus.fetch_en, bus.DecoderEnable, bus.exec_en, bus.mem_rd,
                 bus.mem_wr, bus.reg_we, bus.pc_we, bus.busy};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check strobes mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic st, input logic hr, input logic [6:0] opc,
                     input logic ir, input logic dr, input logic [7:0] exp);
    bus.start      = st;
    bus.halt_req   = hr;
    bus.opcode     = opc;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    #1;
    chk(tag, {24'h0, strb}, {24'h0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.halt_req   = 1'b0;
    bus.opcode     = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    #1;
    chk({tag, "_strb"},  {24'h0, strb}, 32'h0);
    chk({tag, "_trap"},  {31'h0, bus.trap}, 32'h0);
    chk({tag, "_cause"}, {30'h0, bus.trap_cause}, 32'h0);
    chk({tag, "_count"}, bus.instr_count, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    do_reset("reset0");

    // ADD: zero-wait, 4-cycle latency
    cyc("add_idle",   1, 0, 7'h00, 0, 0, 8'h00);
    cyc("add_fetch",  0, 0, 7'h00, 1, 0, 8'h81);
    cyc("add_decode", 0, 0, 7'h33, 0, 0, 8'h41);
    cyc("add_exec",   0, 0, 7'h00, 0, 0, 8'h21);
    cyc("add_wb",     0, 1, 7'h00, 0, 0, 8'h07);
    chk("add_count", bus.instr_count, 32'd1);
    cyc("add_halted", 0, 1, 7'h00, 0, 0, 8'h00);

    // LW with dmem_ready delayed 3 cycles, then continue fetching
    cyc("lw_idle",   1, 0, 7'h00, 0, 0, 8'h00);
    cyc("lw_fetch",  0, 0, 7'h00, 1, 0, 8'h81);
    cyc("lw_decode", 0, 0, 7'h03, 0, 0, 8'h41);
    cyc("lw_exec",   0, 0, 7'h00, 0, 0, 8'h21);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 0, 0, 7'h00, 0, 0, 8'h11);
    cyc("lw_mem_rdy", 0, 0, 7'h00, 0, 1, 8'h11);
    cyc("lw_wb",      0, 0, 7'h00, 0, 0, 8'h07);
    chk("lw_count", bus.instr_count, 32'd2);

    // SW retires on the dmem_ready cycle
    cyc("sw_fetch",    0, 0, 7'h00, 1, 0, 8'h81);
    cyc("sw_decode",   0, 0, 7'h23, 0, 0, 8'h41);
    cyc("sw_exec",     0, 0, 7'h00, 0, 0, 8'h21);
    cyc("sw_mem_wait", 0, 0, 7'h00, 0, 0, 8'h09);
    cyc("sw_mem_rdy",  0, 0, 7'h00, 0, 1, 8'h0B);
    chk("sw_count", bus.instr_count, 32'd3);

    // BEQ retires in EXECUTE, no reg_we
    cyc("beq_fetch",  0, 0, 7'h00, 1, 0, 8'h81);
    cyc("beq_decode", 0, 0, 7'h63, 0, 0, 8'h41);
    cyc("beq_exec",   0, 1, 7'h00, 0, 0, 8'h23);
    cyc("beq_idle",   0, 0, 7'h00, 0, 0, 8'h00);
    chk("beq_count", bus.instr_count, 32'd4);

    // imem_ready arrives on the 16th wait cycle: no trap
    cyc("late_idle", 1, 0, 7'h00, 0, 0, 8'h00);
    for (int i = 0; i < 15; i++) cyc("late_fetch_wait", 0, 0, 7'h00, 0, 0, 8'h81);
    cyc("late_fetch_rdy", 0, 0, 7'h00, 1, 0, 8'h81);
    cyc("late_decode",    0, 0, 7'h33, 0, 0, 8'h41);
    cyc("late_exec",      0, 0, 7'h00, 0, 0, 8'h21);
    cyc("late_wb",        0, 1, 7'h00, 0, 0, 8'h07);
    chk("late_trap",  {31'h0, bus.trap}, 32'h0);
    chk("late_count", bus.instr_count, 32'd5);

    // halt_req during LOAD MEM: still retires, then IDLE
    cyc("hlt_idle",   1, 0, 7'h00, 0, 0, 8'h00);
    cyc("hlt_fetch",  0, 0, 7'h00, 1, 0, 8'h81);
    cyc("hlt_decode", 0, 0, 7'h03, 0, 0, 8'h41);
    cyc("hlt_exec",   0, 0, 7'h00, 0, 0, 8'h21);
    cyc("hlt_mem0",   0, 1, 7'h00, 0, 0, 8'h11);
    cyc("hlt_mem1",   0, 1, 7'h00, 0, 1, 8'h11);
    cyc("hlt_wb",     0, 1, 7'h00, 0, 0, 8'h07);
    cyc("hlt_idle2",  0, 0, 7'h00, 0, 0, 8'h00);
    chk("hlt_count", bus.instr_count, 32'd6);

    // Async reset mid-MEM: strobes drop at once, no retire
    cyc("rmid_idle",   1, 0, 7'h00, 0, 0, 8'h00);
    cyc("rmid_fetch",  0, 0, 7'h00, 1, 0, 8'h81);
    cyc("rmid_decode", 0, 0, 7'h03, 0, 0, 8'h41);
    cyc("rmid_exec",   0, 0, 7'h00, 0, 0, 8'h21);
    bus.start = 1'b0;
    #1;
    chk("rmid_mem", {24'h0, strb}, 32'h11);
    rst = 1'b1;
    #1;
    chk("rmid_strb",  {24'h0, strb}, 32'h0);
    chk("rmid_count", bus.instr_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("rmid_after", 0, 0, 7'h00, 0, 1, 8'h00);

    // imem timeout -> TRAP(2), start ignored
    cyc("ito_idle", 1, 0, 7'h00, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) cyc("ito_fetch_wait", 0, 0, 7'h00, 0, 0, 8'h81);
    cyc("ito_trap", 1, 0, 7'h00, 1, 0, 8'h00);
    chk("ito_trap_flag", {31'h0, bus.trap}, 32'h1);
    chk("ito_cause", {30'h0, bus.trap_cause}, 32'h2);
    do_reset("ito_rst");

    // Illegal opcode -> TRAP(1), sticky through start
    cyc("ill_idle",   1, 0, 7'h00, 0, 0, 8'h00);
    cyc("ill_fetch",  0, 0, 7'h00, 1, 0, 8'h81);
    cyc("ill_decode", 0, 0, 7'h7F, 0, 0, 8'h41);
    cyc("ill_trap0",  1, 0, 7'h33, 1, 1, 8'h00);
    cyc("ill_trap1",  1, 0, 7'h33, 1, 1, 8'h00);
    chk("ill_trap_flag", {31'h0, bus.trap}, 32'h1);
    chk("ill_cause", {30'h0, bus.trap_cause}, 32'h1);
    do_reset("ill_rst");

    // dmem timeout on a LOAD -> TRAP(3)
    cyc("dto_idle",   1, 0, 7'h00, 0, 0, 8'h00);
    cyc("dto_fetch",  0, 0, 7'h00, 1, 0, 8'h81);
    cyc("dto_decode", 0, 0, 7'h03, 0, 0, 8'h41);
    cyc("dto_exec",   0, 0, 7'h00, 0, 0, 8'h21);
    for (int i = 0; i < 16; i++) cyc("dto_mem_wait", 0, 0, 7'h00, 0, 0, 8'h11);
    cyc("dto_trap", 0, 0, 7'h00, 0, 1, 8'h00);
    chk("dto_trap_flag", {31'h0, bus.trap}, 32'h1);
    chk("dto_cause", {30'h0, bus.trap_cause}, 32'h3);
    chk("dto_count", bus.instr_count, 32'd0);
    do_reset("dto_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
